// File: rtl/rr_bus_arbiter_n.sv
// Round-robin / fixed-priority arbiter relaying one client's 4-phase rq/ack
// handshake at a time to a single shared server port.
module rr_bus_arbiter_n #(
    parameter int N_CLIENTS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = $clog2(N_CLIENTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CLIENTS-1:0] client_rq,
    output logic [N_CLIENTS-1:0] client_ack,
    output logic                 server_rq,
    input  logic                 server_ack,
    input  logic                 prio_mode,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshake (4-phase, both sides): requester raises rq and holds it until ack
    // rises, then drops rq; the responder holds ack until rq falls, then drops ack.
    typedef enum logic [1:0] {
        S_IDLE          = 2'd0,
        S_WAIT_SACK     = 2'd1,
        S_WAIT_CRQ_LOW  = 2'd2,
        S_WAIT_SACK_LOW = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_nxt_state;
    logic [N_CLIENTS-1:0] w_rq_s;
    logic                 w_ack_s;
    logic [N_CLIENTS-1:0] r_client_ack;
    logic                 r_server_rq;
    logic                 r_busy;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     r_last;
    logic [N_CLIENTS-1:0] w_nxt_ack;
    logic                 w_nxt_srq;
    logic                 w_nxt_busy;
    logic [IDX_W-1:0]     w_nxt_gidx;
    logic [IDX_W-1:0]     w_nxt_last;
    logic                 w_any;
    logic                 w_hi_vld;
    logic [IDX_W-1:0]     w_hi;
    logic [IDX_W-1:0]     w_lo;
    logic [IDX_W-1:0]     w_win;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_rq_s  = client_rq;
            assign w_ack_s = server_ack;
        end else begin : g_sync
            logic [N_CLIENTS-1:0]   r_rq_sync [SYNC_STAGES];
            logic [SYNC_STAGES-1:0] r_ack_sync;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_rq_sync[s] <= '0;
                    end
                    r_ack_sync <= '0;
                end else begin
                    r_rq_sync[0]  <= client_rq;
                    r_ack_sync[0] <= server_ack;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_rq_sync[s]  <= r_rq_sync[s-1];
                        r_ack_sync[s] <= r_ack_sync[s-1];
                    end
                end
            end

            assign w_rq_s  = r_rq_sync[SYNC_STAGES-1];
            assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
        end
    endgenerate

    // w_hi: lowest requester above the last winner; w_lo: lowest requester overall.
    // Round-robin wraps to w_lo when nobody sits above the pointer.
    always_comb begin
        w_any    = |w_rq_s;
        w_hi_vld = 1'b0;
        w_hi     = '0;
        w_lo     = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (w_rq_s[i]) begin
                w_lo = IDX_W'(i);
                if (i > int'(r_last)) begin
                    w_hi     = IDX_W'(i);
                    w_hi_vld = 1'b1;
                end
            end
        end
        w_win = (!prio_mode && w_hi_vld) ? w_hi : w_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_client_ack <= '0;
            r_server_rq  <= 1'b0;
            r_busy       <= 1'b0;
            r_grant_idx  <= '0;
            r_last       <= IDX_W'(N_CLIENTS - 1);
        end else begin
            r_state      <= w_nxt_state;
            r_client_ack <= w_nxt_ack;
            r_server_rq  <= w_nxt_srq;
            r_busy       <= w_nxt_busy;
            r_grant_idx  <= w_nxt_gidx;
            r_last       <= w_nxt_last;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE:          if (w_any)                   w_nxt_state = S_WAIT_SACK;
            S_WAIT_SACK:     if (w_ack_s)                 w_nxt_state = S_WAIT_CRQ_LOW;
            S_WAIT_CRQ_LOW:  if (!w_rq_s[r_grant_idx])    w_nxt_state = S_WAIT_SACK_LOW;
            S_WAIT_SACK_LOW: if (!w_ack_s)                w_nxt_state = S_IDLE;
            default:                                      w_nxt_state = S_IDLE;
        endcase
    end

    // r_grant_idx doubles as the latched winner for the whole transaction.
    always_comb begin
        w_nxt_ack  = r_client_ack;
        w_nxt_srq  = r_server_rq;
        w_nxt_busy = r_busy;
        w_nxt_gidx = r_grant_idx;
        w_nxt_last = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_nxt_gidx = w_win;
                    w_nxt_srq  = 1'b1;
                    w_nxt_busy = 1'b1;
                end
            end
            S_WAIT_SACK: begin
                if (w_ack_s) begin
                    w_nxt_ack              = '0;
                    w_nxt_ack[r_grant_idx] = 1'b1;
                end
            end
            S_WAIT_CRQ_LOW: begin
                if (!w_rq_s[r_grant_idx]) begin
                    w_nxt_srq = 1'b0;
                end
            end
            S_WAIT_SACK_LOW: begin
                if (!w_ack_s) begin
                    w_nxt_ack  = '0;
                    w_nxt_busy = 1'b0;
                    w_nxt_last = r_grant_idx;
                end
            end
            default: ;
        endcase
    end

    assign client_ack = r_client_ack;
    assign server_rq  = r_server_rq;
    assign busy       = r_busy;
    assign grant_idx  = r_grant_idx;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_rr_bus_arbiter_n.sv
// Directed bench for rr_bus_arbiter_n: one instance without synchronisers,
// one with two-stage synchronisers for input latency checks.
module tb_rr_bus_arbiter_n;

  logic       clk;
  logic       rst_n;
  logic [3:0] rq_a;
  logic [3:0] client_ack_a;
  logic       server_rq_a;
  logic       server_ack_a;
  logic       prio_a;
  logic [1:0] grant_idx_a;
  logic       busy_a;
  logic [1:0] state_a;
  logic [3:0] rq_b;
  logic [3:0] client_ack_b;
  logic       server_rq_b;
  logic       server_ack_b;
  logic [1:0] grant_idx_b;
  logic       busy_b;
  logic [1:0] state_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  rr_bus_arbiter_n #(.N_CLIENTS(4), .SYNC_STAGES(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .client_rq(rq_a), .client_ack(client_ack_a),
    .server_rq(server_rq_a), .server_ack(server_ack_a), .prio_mode(prio_a),
    .grant_idx(grant_idx_a), .busy(busy_a), .dbg_state(state_a)
  );

  rr_bus_arbiter_n #(.N_CLIENTS(4), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .client_rq(rq_b), .client_ack(client_ack_b),
    .server_rq(server_rq_b), .server_ack(server_ack_b), .prio_mode(1'b0),
    .grant_idx(grant_idx_b), .busy(busy_b), .dbg_state(state_b)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // client_ack must never be multi-hot on either instance
  always @(negedge clk) begin
    check("onehot_a", 32'($countones(client_ack_a) <= 1), 32'd1);
    check("onehot_b", 32'($countones(client_ack_b) <= 1), 32'd1);
  end

  // driver tasks
  task automatic wait_srq(input logic lvl, input string tag);
    for (int c = 0; c < 50 && server_rq_a !== lvl; c++) @(negedge clk);
    check({tag, "_srq_wait"}, 32'(server_rq_a), 32'(lvl));
  endtask

  task automatic wait_cack(input string tag);
    for (int c = 0; c < 50 && client_ack_a == 4'b0; c++) @(negedge clk);
    check({tag, "_cack_wait"}, 32'(client_ack_a != 4'b0), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 50 && busy_a !== 1'b0; c++) @(negedge clk);
    check({tag, "_idle_wait"}, 32'(busy_a), 32'd0);
  endtask

  // One full transaction on instance a; bench plays both granted client and server.
  task automatic do_txn(input logic [3:0] pattern, input string tag);
    logic [31:0] exp_idx;
    logic [3:0]  exp_oh;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    exp_idx = exp_q.pop_front();
    exp_oh  = 4'b0001 << exp_idx;
    rq_a = pattern;
    wait_srq(1'b1, tag);
    check({tag, "_gidx"}, 32'(grant_idx_a), exp_idx);
    check({tag, "_busy"}, 32'(busy_a), 32'd1);
    server_ack_a = 1'b1;
    wait_cack(tag);
    check({tag, "_cack"}, 32'(client_ack_a), 32'(exp_oh));
    rq_a = pattern & ~exp_oh;
    wait_srq(1'b0, tag);
    server_ack_a = 1'b0;
    wait_idle(tag);
    check({tag, "_cack_low"}, 32'(client_ack_a), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    rq_a         = '0;
    server_ack_a = 1'b0;
    prio_a       = 1'b0;
    rq_b         = '0;
    server_ack_b = 1'b0;

    // reset values
    #3;
    check("rst_cack", 32'(client_ack_a), 32'd0);
    check("rst_srq", 32'(server_rq_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_gidx", 32'(grant_idx_a), 32'd0);
    check("rst_state", 32'(state_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // test 1: single request, cycle-exact 4-phase
    @(negedge clk);
    rq_a = 4'b0001;
    check("t1_srq_pre", 32'(server_rq_a), 32'd0);
    @(negedge clk);
    check("t1_srq", 32'(server_rq_a), 32'd1);
    check("t1_busy", 32'(busy_a), 32'd1);
    check("t1_gidx", 32'(grant_idx_a), 32'd0);
    check("t1_state_sack", 32'(state_a), 32'd1);
    @(negedge clk);
    check("t1_cack_pre", 32'(client_ack_a), 32'd0);
    server_ack_a = 1'b1;
    @(negedge clk);
    check("t1_cack", 32'(client_ack_a), 32'b0001);
    check("t1_state_crq", 32'(state_a), 32'd2);
    rq_a = 4'b0000;
    @(negedge clk);
    check("t1_srq_low", 32'(server_rq_a), 32'd0);
    check("t1_busy_hold", 32'(busy_a), 32'd1);
    check("t1_state_sacklow", 32'(state_a), 32'd3);
    server_ack_a = 1'b0;
    @(negedge clk);
    check("t1_busy_low", 32'(busy_a), 32'd0);
    check("t1_cack_low", 32'(client_ack_a), 32'd0);
    check("t1_gidx_hold", 32'(grant_idx_a), 32'd0);
    check("t1_state_idle", 32'(state_a), 32'd0);

    // stray server ack while idle is ignored
    server_ack_a = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ack_srq", 32'(server_rq_a), 32'd0);
    check("idle_ack_cack", 32'(client_ack_a), 32'd0);
    check("idle_ack_state", 32'(state_a), 32'd0);
    server_ack_a = 1'b0;

    // test 2: round-robin fairness from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    for (int t = 0; t < 6; t++) do_txn(4'b1111, "t2_rr");

    // test 3: fixed priority, client 1 always wins over 3
    prio_a = 1'b1;
    for (int t = 0; t < 3; t++) exp_q.push_back(1);
    for (int t = 0; t < 3; t++) do_txn(4'b1010, "t3_fp");

    // test 4: request arriving mid-transaction is deferred
    prio_a = 1'b0;
    rq_a   = 4'b0100;
    wait_srq(1'b1, "t4");
    rq_a = 4'b0101;
    @(negedge clk);
    check("t4_gidx_mid", 32'(grant_idx_a), 32'd2);
    check("t4_cack_mid", 32'(client_ack_a), 32'd0);
    check("t4_state_mid", 32'(state_a), 32'd1);
    server_ack_a = 1'b1;
    wait_cack("t4");
    check("t4_cack", 32'(client_ack_a), 32'b0100);
    rq_a = 4'b0001;
    wait_srq(1'b0, "t4");
    server_ack_a = 1'b0;
    wait_idle("t4");
    check("t4_gidx_hold", 32'(grant_idx_a), 32'd2);
    exp_q.push_back(0);
    do_txn(4'b0001, "t4_next");

    // test 5: asynchronous reset while in WAIT_CRQ_LOW
    rq_a = 4'b0010;
    wait_srq(1'b1, "t5");
    server_ack_a = 1'b1;
    wait_cack("t5");
    check("t5_state_pre", 32'(state_a), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_cack", 32'(client_ack_a), 32'd0);
    check("t5_async_srq", 32'(server_rq_a), 32'd0);
    check("t5_async_busy", 32'(busy_a), 32'd0);
    check("t5_async_gidx", 32'(grant_idx_a), 32'd0);
    check("t5_async_state", 32'(state_a), 32'd0);
    @(negedge clk);
    rq_a         = 4'b0000;
    server_ack_a = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    exp_q.push_back(0);
    do_txn(4'b1111, "t5_first");
    rq_a = 4'b0000;

    // test 6: two-stage synchronisers add latency on both directions
    @(negedge clk);
    rq_b = 4'b0001;
    repeat (2) @(negedge clk);
    check("t6_srq_early", 32'(server_rq_b), 32'd0);
    @(negedge clk);
    check("t6_srq_3cyc", 32'(server_rq_b), 32'd1);
    check("t6_gidx", 32'(grant_idx_b), 32'd0);
    server_ack_b = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_cack_early", 32'(client_ack_b), 32'd0);
    @(negedge clk);
    check("t6_cack_3cyc", 32'(client_ack_b), 32'b0001);
    rq_b = 4'b0000;
    for (int c = 0; c < 50 && server_rq_b !== 1'b0; c++) @(negedge clk);
    check("t6_srq_low", 32'(server_rq_b), 32'd0);
    server_ack_b = 1'b0;
    for (int c = 0; c < 50 && busy_b !== 1'b0; c++) @(negedge clk);
    check("t6_busy_low", 32'(busy_b), 32'd0);
    check("t6_cack_low", 32'(client_ack_b), 32'd0);

    // final report
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
